pipemem_ctrl: RTL and testbench

PIPEMEM_CTRL -- requirements
Module: pipemem_ctrl

---
 rtl/pipemem_ctrl_pkg.sv | 37 +++
 rtl/pipemem_ctrl_pipemwreg.sv | 30 +++
 rtl/pipemem_ctrl.sv | 134 +++++++++++++
 tb/tb_pipemem_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipemem_ctrl_pkg.sv
// Shared definitions for the pipeline MEM-stage data-memory controller:
// timeout/poison defaults, FSM encoding and the MEM/WB register bundle.
package pipemem_ctrl_pkg;

    localparam int unsigned TIMEOUT_DEF = 255;
    localparam logic [31:0] POISON_DEF  = 32'hDEADBEEF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mo;
        logic [31:0] alu;
        logic [4:0]  rn;
    } mw_bus_t;

    // Value written to MEM/WB load data: 0 for non-loads, poison when forced complete.
    function automatic logic [31:0] load_data(input logic        is_load,
                                              input logic        ack,
                                              input logic [31:0] rdata,
                                              input logic [31:0] poison);
        logic [31:0] result;
        if (!is_load) begin
            result = 32'h0000_0000;
        end else if (ack) begin
            result = rdata;
        end else begin
            result = poison;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipemem_ctrl_pipemwreg.sv
// MEM/WB pipeline register: loads on enable, inserts a bubble (controls
// cleared, data held) while the memory stage is stalled.
module pipemwreg
    import pipemem_ctrl_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    en,
    input  logic    bubble,
    input  mw_bus_t d,
    output mw_bus_t q
);

    mw_bus_t q_r;

    // MEM/WB state: reset, bubble, load or hold
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r <= '0;
        end else if (bubble) begin
            q_r.wreg  <= 1'b0;
            q_r.m2reg <= 1'b0;
        end else if (en) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipemem_ctrl.sv
// MEM-stage data-memory controller: req/ack handshake with wait-state
// stalling, bounded wait with poisoned completion, and the MEM/WB register.
module pipemem_ctrl
    import pipemem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter logic [31:0] POISON  = POISON_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mvalid,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic        merr
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

    mem_state_t  state_r;
    mem_state_t  state_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_s;
    logic        merr_r;
    logic        merr_s;
    logic        memop_s;
    logic        busy_s;
    logic        req_s;
    logic        timeout_hit_s;
    logic        stall_s;
    mw_bus_t     w_in_s;
    mw_bus_t     w_out_s;

    // Request/stall decode and next-state logic
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        merr_s     = merr_r;

        memop_s       = mvalid & (mm2reg | mwmem);
        busy_s        = (state_r == ST_BUSY);
        req_s         = !reset & ((memop_s & !busy_s) | busy_s);
        timeout_hit_s = busy_s & !dmem_ack & (wait_cnt_r == TIMEOUT_LAST);
        stall_s       = req_s & !dmem_ack & !timeout_hit_s;

        case (state_r)
            ST_IDLE: begin
                if (memop_s & !dmem_ack) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dmem_ack | timeout_hit_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        // Counts every wait cycle of the access, including the first one issued
        // from IDLE, so forced completion lands on request cycle TIMEOUT.
        if (stall_s) begin
            wait_cnt_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_s = 8'd0;
        end

        if (timeout_hit_s) begin
            merr_s = 1'b1;
        end else begin
            merr_s = merr_r;
        end

        w_in_s.wreg  = mwreg & mvalid;
        w_in_s.m2reg = mm2reg & mvalid;
        w_in_s.mo    = load_data(mm2reg & mvalid, dmem_ack, dmem_rdata, POISON);
        w_in_s.alu   = malu;
        w_in_s.rn    = mrn;
    end

    // Controller state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 8'd0;
            merr_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            merr_r     <= merr_s;
        end
    end

    pipemwreg u_mwreg (
        .clock  (clock),
        .reset  (reset),
        .en     (!stall_s),
        .bubble (stall_s),
        .d      (w_in_s),
        .q      (w_out_s)
    );

    assign dmem_req   = req_s;
    assign dmem_we    = req_s & mwmem;
    assign dmem_addr  = malu[31:2];
    assign dmem_wdata = mb;
    assign mem_stall  = stall_s;
    assign wwreg      = w_out_s.wreg;
    assign wm2reg     = w_out_s.m2reg;
    assign wmo        = w_out_s.mo;
    assign walu       = w_out_s.alu;
    assign wrn        = w_out_s.rn;
    assign merr       = merr_r;

endmodule

// File: tb/tb_pipemem_ctrl.sv
// Self-checking bench for pipemem_ctrl: vector table, directed corner
// sequences and randomized instruction stream against a per-instruction model.
module tb_pipemem_ctrl;
    import pipemem_ctrl_pkg::*;

    localparam int          TO     = 255;
    localparam logic [31:0] PZ     = 32'hDEADBEEF;
    localparam int          NEVER  = 100000;

    typedef struct {
        logic        v;
        logic        wr;
        logic        ld;
        logic        st;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [29:0] e_addr;
        logic        e_wreg;
        logic        e_m2reg;
        logic [31:0] e_mo;
        logic [31:0] e_alu;
        logic [4:0]  e_rn;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        mvalid, mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        dmem_req, dmem_we;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall, wwreg, wm2reg, merr;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;

    // expected MEM/WB contents and sticky error
    logic        ew_wreg, ew_m2reg, e_merr;
    logic [31:0] ew_mo, ew_alu;
    logic [4:0]  ew_rn;

    int errors = 0;
    int checks = 0;

    pipemem_ctrl dut (
        .clock(clock), .reset(reset), .mvalid(mvalid), .mwreg(mwreg),
        .mm2reg(mm2reg), .mwmem(mwmem), .malu(malu), .mb(mb), .mrn(mrn),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo),
        .walu(walu), .wrn(wrn), .merr(merr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name);
        chk({name, "/w"}, {wwreg, wm2reg, wmo, walu, wrn},
            {ew_wreg, ew_m2reg, ew_mo, ew_alu, ew_rn});
        chk({name, "/merr"}, merr, e_merr);
    endtask

    task automatic drive(input instr_t in);
        mvalid = in.v;
        mwreg  = in.wr;
        mm2reg = in.ld;
        mwmem  = in.st;
        malu   = in.alu;
        mb     = in.b;
        mrn    = in.rn;
    endtask

    // Holds one instruction in M until the model says it leaves; memory acks
    // after d wait cycles. Called and returns at a falling edge.
    task automatic run_instr(input instr_t in, input int d, input logic [31:0] ack_data,
                             input string name, output int stalls);
        logic memop, stall_e, ack_now;
        memop  = in.v & (in.ld | in.st);
        stalls = 0;
        for (int k = 0; k <= TO; k++) begin
            drive(in);
            ack_now    = memop ? (k == d) : ($urandom_range(0, 3) == 0);
            dmem_ack   = ack_now;
            dmem_rdata = ack_now ? ack_data : $urandom;
            #1;
            stall_e = memop && (k < d) && (k < TO - 1);
            chk({name, "/ctl"}, {dmem_req, dmem_we, mem_stall},
                {memop, memop & in.st, stall_e});
            if (memop) begin
                chk({name, "/addr"}, {dmem_addr, dmem_wdata}, {in.alu[31:2], in.b});
            end
            if (mem_stall) stalls++;
            if (stall_e) begin
                ew_wreg  = 1'b0;
                ew_m2reg = 1'b0;
            end else begin
                ew_wreg  = in.v & in.wr;
                ew_m2reg = in.v & in.ld;
                ew_mo    = (in.v & in.ld) ? ((memop && k == d) ? ack_data : PZ) : 32'h0;
                ew_alu   = in.alu;
                ew_rn    = in.rn;
            end
            if (memop && k == TO - 1 && d > k) e_merr = 1'b1;
            @(negedge clock);
            chk_w(name);
            if (!stall_e) break;
        end
    endtask

    function automatic instr_t mk(input logic v, wr, ld, st, input logic [31:0] alu, b,
                                  input logic [4:0] rn);
        instr_t r;
        r.v = v; r.wr = wr; r.ld = ld; r.st = st; r.alu = alu; r.b = b; r.rn = rn;
        return r;
    endfunction

    function automatic vec_t mv(input instr_t in, input logic ack, input logic [31:0] rd,
                                input logic e_req, e_we, input logic [29:0] e_addr,
                                input logic e_wreg, e_m2reg,
                                input logic [31:0] e_mo, e_alu, input logic [4:0] e_rn);
        vec_t r;
        r.in = in; r.ack = ack; r.rdata = rd; r.e_req = e_req; r.e_we = e_we;
        r.e_addr = e_addr; r.e_wreg = e_wreg; r.e_m2reg = e_m2reg;
        r.e_mo = e_mo; r.e_alu = e_alu; r.e_rn = e_rn;
        return r;
    endfunction

    task automatic model_reset();
        ew_wreg = 1'b0; ew_m2reg = 1'b0; ew_mo = 32'h0; ew_alu = 32'h0; ew_rn = 5'd0;
        e_merr = 1'b0;
    endtask

    initial begin
        vec_t   vt[6];
        instr_t nop, ins;
        int     st_cnt, op;

        nop = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        vt[0] = mv(mk(1, 1, 1, 0, 32'h100, 32'h0, 5'd5), 1, 32'h12345678,
                   1, 0, 30'h40, 1, 1, 32'h12345678, 32'h100, 5'd5);
        vt[1] = mv(mk(1, 1, 0, 0, 32'h7, 32'h11, 5'd3), 0, 32'h0,
                   0, 0, 30'h1, 1, 0, 32'h0, 32'h7, 5'd3);
        vt[2] = mv(mk(1, 0, 0, 1, 32'h204, 32'hCAFEF00D, 5'd0), 1, 32'hFFFF,
                   1, 1, 30'h81, 0, 0, 32'h0, 32'h204, 5'd0);
        vt[3] = mv(mk(0, 1, 1, 0, 32'h40, 32'h0, 5'd9), 1, 32'hAAAA,
                   0, 0, 30'h10, 0, 0, 32'h0, 32'h40, 5'd9);
        vt[4] = mv(mk(0, 1, 1, 0, 32'h80, 32'h0, 5'd4), 0, 32'h0,
                   0, 0, 30'h20, 0, 0, 32'h0, 32'h80, 5'd4);
        vt[5] = mv(mk(1, 1, 1, 0, 32'h3, 32'h0, 5'd31), 1, 32'h0BADF00D,
                   1, 0, 30'h0, 1, 1, 32'h0BADF00D, 32'h3, 5'd31);

        // reset state
        reset = 1'b1; drive(nop); dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(negedge clock);
        model_reset();
        chk("reset/ctl", {dmem_req, mem_stall}, 2'b00);
        chk_w("reset");
        reset = 1'b0;

        // table of single-cycle (zero-wait or non-memory) vectors
        foreach (vt[i]) begin
            drive(vt[i].in);
            dmem_ack = vt[i].ack; dmem_rdata = vt[i].rdata;
            #1;
            chk($sformatf("vec%0d/ctl", i), {dmem_req, dmem_we, mem_stall},
                {vt[i].e_req, vt[i].e_we, 1'b0});
            chk($sformatf("vec%0d/addr", i), dmem_addr, vt[i].e_addr);
            @(negedge clock);
            ew_wreg = vt[i].e_wreg; ew_m2reg = vt[i].e_m2reg; ew_mo = vt[i].e_mo;
            ew_alu = vt[i].e_alu; ew_rn = vt[i].e_rn;
            chk_w($sformatf("vec%0d", i));
        end

        // store with three wait cycles
        run_instr(mk(1, 0, 0, 1, 32'h204, 32'hCAFEF00D, 5'd2), 3, 32'h0, "sw3", st_cnt);
        chk("sw3/stalls", st_cnt, 3);

        // ack arrives on the very cycle the timeout would fire: ack wins
        run_instr(mk(1, 1, 1, 0, 32'h300, 32'h0, 5'd7), TO - 1, 32'h55, "acktmo", st_cnt);
        chk("acktmo/stalls", st_cnt, TO - 1);
        chk("acktmo/wmo", wmo, 32'h55);

        // reset while BUSY, then a late ack with no instruction present
        ins = mk(1, 1, 1, 0, 32'h400, 32'h0, 5'd8);
        drive(ins); dmem_ack = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rstbusy/ctl", {dmem_req, mem_stall}, 2'b00);
        @(negedge clock);
        model_reset();
        chk_w("rstbusy");
        reset = 1'b0; drive(nop); dmem_ack = 1'b1; dmem_rdata = 32'h77;
        #1;
        chk("lateack/ctl", {dmem_req, mem_stall}, 2'b00);
        @(negedge clock);
        chk_w("lateack");
        dmem_ack = 1'b0;

        // randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            op  = $urandom_range(0, 2);
            ins = mk(($urandom_range(0, 4) != 0), $urandom_range(0, 1), (op == 1), (op == 2),
                     $urandom, $urandom, $urandom_range(0, 31));
            run_instr(ins, $urandom_range(0, 4), $urandom, $sformatf("rnd%0d", n), st_cnt);
        end

        // load never acked: forced completion with poison, sticky error
        run_instr(mk(1, 1, 1, 0, 32'h500, 32'h0, 5'd6), NEVER, 32'h0, "tmo", st_cnt);
        chk("tmo/stalls", st_cnt, TO - 1);
        chk("tmo/wmo", {wmo, merr}, {PZ, 1'b1});
        for (int n = 0; n < 3; n++) begin
            run_instr(mk(1, 1, 0, 0, 32'h9 + n, 32'h0, 5'd1), 0, 32'h0, "post", st_cnt);
        end
        reset = 1'b1;
        @(negedge clock);
        model_reset();
        chk_w("final_reset");
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
